pcs_descrambler: RTL and testbench
==================================

// Module: pcs_descrambler
//
// PURPOSE
// - 10GBASE-R receive-path self-synchronizing descrambler, polynomial G(x) = 1 + x^39 + x^58 (IEEE 802.3 Cl.49).
// - Sits after block sync / gearbox: it takes the 64-bit payload with the 2-bit sync header already stripped.
// - It delivers the descrambled payload to the 64b/66b decoder.
// - No header handling, no lock detection; one word per valid cycle.
//
// PARAMETERS
// - PCS_DATA_WIDTH  64  payload width. Only 64 is supported; elaboration error otherwise.
//
// PORTS
// - clk            in   1                   single clock; all logic on rising edge
// - rst            in   1                   synchronous, active-high reset
// - in_data        in   PCS_DATA_WIDTH      scrambled payload; bit 0 is first on the wire
// - in_data_valid  in   1                   in_data is meaningful this cycle
// - out_data       out  PCS_DATA_WIDTH      descrambled payload, registered
// - out_data_valid out  1                   out_data updated this cycle (optional to connect)
//
// BEHAVIOUR
// - State: state[57:0] holds the last 58 received *scrambled* bits. state[57] is the newest bit.
// - Per valid word, form x[121:0] = {in_data, state}.
//   - out_data[i] = x[i+58] ^ x[i+19] ^ x[i], for i = 0..63.
//   - This equals r(n) ^ r(n-39) ^ r(n-58).
// - State update on valid: state <= in_data[63:6].
//   - Uses scrambled input bits, never output bits (self-synchronizing).
// - Latency: 1 clk. Word sampled at edge N appears on out_data after edge N, with out_data_valid=1 for that cycle.
// - in_data_valid=0: state unchanged; out_data holds its last value; out_data_valid=0.
//   - Gaps of any length are transparent to the bit stream.
// - Reset (rst=1 at edge):
//   - state <= 0, out_data <= 0, out_data_valid <= 0.
//   - Reset has priority over a simultaneous valid word, which is dropped.
// - Reset mid-stream: the first 58 output bits after reset may be wrong (zero history).
//   - Output becomes correct automatically once 58 bits have been received; no other recovery is needed.
// - Back-to-back valid words: full throughput, one word per clk.
// - No X propagation: all outputs are defined from the first clock with rst=1.
//
// TESTING
// - Impulse, reset then in=0x8000_0000_0000_0000 -> out=0x8000_0000_0000_0000.
//   - Next valid in=0 -> out=0x0200_0040_0000_0000.
//   - Next valid in=0 -> out=0.
// - Taps, reset then in=0x0000_0000_0000_0001 -> out=0x0400_0080_0000_0001.
//   - Next valid in=0 -> out=0.
// - Round trip:
//   - Scramble 0x7B2A_AAD5_5555_5555, 0x46FF_0044_3322_1100, 0x5E86_44A8_B207_0707 (frame start/data/terminate) with a golden 58-bit serial scrambler.
//   - Scrambler seed = 0; feed the three words back-to-back and again with 1-cycle valid gaps.
//   - Required: out equals the originals, one clk after each valid.
// - Self-sync:
//   - Golden scrambler seeded with a random nonzero state, random stream, DUT reset with zero state.
//   - Required: words 2 onward match exactly.
//   - out_data and out_data_valid hold during in_data_valid=0.
// - Reset priority / mid-stream:
//   - Assert rst together with in_data_valid=1 -> out_data=0, out_data_valid=0.
//   - The next word is descrambled against zero state.
// - Random long run: 10k random words with random valid gaps vs the bit-serial reference model; zero mismatches.

Source files
------------

// File: rtl/pcs_descrambler.sv
`default_nettype none
//==============================================================================
// Module      : pcs_descrambler
// Description : 10GBASE-R receive self-synchronizing descrambler, G(x) = 1 + x^39 + x^58
// Revision    : 1.0 - initial release
//==============================================================================
module pcs_descrambler #(
   parameter int PCS_DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [PCS_DATA_WIDTH-1:0] in_data,
   input  logic                      in_data_valid,
   output logic [PCS_DATA_WIDTH-1:0] out_data,
   output logic                      out_data_valid
);

   localparam int c_STATE_WIDTH = 58;
   localparam int c_TAP         = 39;
   localparam int c_MID_OFFSET  = c_STATE_WIDTH - c_TAP;
   localparam int c_X_WIDTH     = PCS_DATA_WIDTH + c_STATE_WIDTH;

   if (PCS_DATA_WIDTH != 64) begin : g_width_check
      $error("pcs_descrambler: PCS_DATA_WIDTH must be 64");
   end

   logic [c_STATE_WIDTH-1:0]  r_state;
   logic [PCS_DATA_WIDTH-1:0] r_out_data;
   logic                      r_out_data_valid;
   logic [c_X_WIDTH-1:0]      w_x;
   logic [PCS_DATA_WIDTH-1:0] w_descrambled;

   // History sits below the new word so bit i sees r(n), r(n-39), r(n-58) at fixed offsets.
   assign w_x = {in_data, r_state};

   for (genvar i = 0; i < PCS_DATA_WIDTH; i++) begin : g_bit
      assign w_descrambled[i] = w_x[i+c_STATE_WIDTH] ^ w_x[i+c_MID_OFFSET] ^ w_x[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= '0;
         r_out_data       <= '0;
         r_out_data_valid <= 1'b0;
      end else begin
         r_out_data_valid <= in_data_valid;
         if (in_data_valid) begin
            // Keep the received (scrambled) bits so the descrambler resynchronizes on its own.
            r_state    <= in_data[PCS_DATA_WIDTH-1 -: c_STATE_WIDTH];
            r_out_data <= w_descrambled;
         end
      end
   end

   assign out_data       = r_out_data;
   assign out_data_valid = r_out_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_pcs_descrambler.sv
`default_nettype none
//==============================================================================
// Module      : tb_pcs_descrambler
// Description : Directed and random self-checking bench for pcs_descrambler
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pcs_descrambler;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_data;
   logic        in_data_valid;
   logic [63:0] out_data;
   logic        out_data_valid;

   int checks = 0;
   int errors = 0;

   pcs_descrambler #(.PCS_DATA_WIDTH(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_data        (in_data),
      .in_data_valid  (in_data_valid),
      .out_data       (out_data),
      .out_data_valid (out_data_valid)
   );

   always #5 clk = ~clk;

   // Bit-serial golden scrambler; h[57] is the newest scrambled bit, h[0] is r(n-58).
   function automatic logic [63:0] scramble(input logic [63:0] d, input logic [57:0] h_in,
                                            output logic [57:0] h_out);
      logic [57:0] h;
      logic [63:0] r;
      h = h_in;
      for (int i = 0; i < 64; i++) begin
         r[i] = d[i] ^ h[19] ^ h[0];
         h    = {r[i], h[57:1]};
      end
      h_out = h;
      return r;
   endfunction

   function automatic logic [63:0] descramble(input logic [63:0] r, input logic [57:0] h_in,
                                              output logic [57:0] h_out);
      logic [57:0] h;
      logic [63:0] d;
      h = h_in;
      for (int i = 0; i < 64; i++) begin
         d[i] = r[i] ^ h[19] ^ h[0];
         h    = {r[i], h[57:1]};
      end
      h_out = h;
      return d;
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic cycle(input logic r, input logic v, input logic [63:0] d);
      rst           = r;
      in_data_valid = v;
      in_data       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b1, rand64());
      cycle(1'b1, 1'b1, rand64());
      checks++;
      if (out_data !== 64'h0 || out_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: out_data=%h valid=%b, required 0/0", out_data, out_data_valid);
      end
   endtask

   task automatic test_impulse();
      logic [63:0] vin [3];
      logic [63:0] vexp [3];
      vin  = '{64'h8000_0000_0000_0000, 64'h0, 64'h0};
      vexp = '{64'h8000_0000_0000_0000, 64'h0200_0040_0000_0000, 64'h0};
      cycle(1'b1, 1'b0, 64'h0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, vin[k]);
         checks++;
         if (out_data !== vexp[k] || out_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL impulse[%0d]: out_data=%h valid=%b, required %h/1", k, out_data,
                     out_data_valid, vexp[k]);
         end
      end
   endtask

   task automatic test_taps();
      logic [63:0] vin [2];
      logic [63:0] vexp [2];
      vin  = '{64'h0000_0000_0000_0001, 64'h0};
      vexp = '{64'h0400_0080_0000_0001, 64'h0};
      cycle(1'b1, 1'b0, 64'h0);
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 1'b1, vin[k]);
         checks++;
         if (out_data !== vexp[k] || out_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL taps[%0d]: out_data=%h valid=%b, required %h/1", k, out_data,
                     out_data_valid, vexp[k]);
         end
      end
   endtask

   task automatic test_round_trip();
      logic [63:0] orig [3];
      logic [63:0] scr  [3];
      logic [57:0] h;
      orig = '{64'h7B2A_AAD5_5555_5555, 64'h46FF_0044_3322_1100, 64'h5E86_44A8_B207_0707};
      for (int gap = 0; gap < 2; gap++) begin
         h = '0;
         for (int k = 0; k < 3; k++) scr[k] = scramble(orig[k], h, h);
         cycle(1'b1, 1'b0, 64'h0);
         for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, scr[k]);
            checks++;
            if (out_data !== orig[k] || out_data_valid !== 1'b1) begin
               errors++;
               $display("FAIL round_trip gap=%0d word=%0d: out_data=%h valid=%b, required %h/1",
                        gap, k, out_data, out_data_valid, orig[k]);
            end
            if (gap == 1) begin
               cycle(1'b0, 1'b0, rand64());
               checks++;
               if (out_data !== orig[k] || out_data_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL round_trip_gap word=%0d: out_data=%h valid=%b, required %h/0",
                           k, out_data, out_data_valid, orig[k]);
               end
            end
         end
      end
   endtask

   task automatic test_self_sync();
      logic [63:0] seed64;
      logic [57:0] h;
      logic [63:0] d [6];
      logic [63:0] s [6];
      seed64 = rand64();
      h      = seed64[57:0] | 58'h1;
      for (int k = 0; k < 6; k++) begin
         d[k] = rand64();
         s[k] = scramble(d[k], h, h);
      end
      cycle(1'b1, 1'b0, 64'h0);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0, 1'b1, s[k]);
         if (k >= 1) begin
            checks++;
            if (out_data !== d[k] || out_data_valid !== 1'b1) begin
               errors++;
               $display("FAIL self_sync word=%0d: out_data=%h valid=%b, required %h/1", k,
                        out_data, out_data_valid, d[k]);
            end
         end
         if (k == 2) begin
            for (int g = 0; g < 3; g++) begin
               cycle(1'b0, 1'b0, rand64());
               checks++;
               if (out_data !== d[2] || out_data_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL self_sync_hold gap=%0d: out_data=%h valid=%b, required %h/0",
                           g, out_data, out_data_valid, d[2]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_priority();
      logic [57:0] h;
      logic [63:0] d;
      logic [63:0] exp_d;
      cycle(1'b1, 1'b0, 64'h0);
      cycle(1'b0, 1'b1, rand64());
      cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      cycle(1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
      checks++;
      if (out_data !== 64'h0 || out_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority: out_data=%h valid=%b, required 0/0", out_data,
                  out_data_valid);
      end
      d     = 64'h0123_4567_89AB_CDEF;
      exp_d = descramble(d, 58'h0, h);
      cycle(1'b0, 1'b1, d);
      checks++;
      if (out_data !== exp_d || out_data_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_zero_state: out_data=%h valid=%b, required %h/1", out_data,
                  out_data_valid, exp_d);
      end
   endtask

   task automatic test_random_long();
      logic [57:0] h;
      logic [63:0] d;
      logic [63:0] exp_d;
      logic [63:0] last;
      h    = '0;
      last = '0;
      cycle(1'b1, 1'b0, 64'h0);
      for (int k = 0; k < 10000; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            cycle(1'b0, 1'b0, rand64());
            checks++;
            if (out_data !== last || out_data_valid !== 1'b0) begin
               errors++;
               $display("FAIL random_idle word=%0d: out_data=%h valid=%b, required %h/0", k,
                        out_data, out_data_valid, last);
            end
         end
         d     = rand64();
         exp_d = descramble(d, h, h);
         cycle(1'b0, 1'b1, d);
         last = exp_d;
         checks++;
         if (out_data !== exp_d || out_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL random_word=%0d: out_data=%h valid=%b, required %h/1", k, out_data,
                     out_data_valid, exp_d);
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      in_data_valid = 1'b0;
      in_data       = 64'h0;
      test_reset();
      test_impulse();
      test_taps();
      test_round_trip();
      test_self_sync();
      test_reset_priority();
      test_random_long();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
